// File: rtl/moore_seq_detector_pkg.sv
// Shared defaults and helpers for the serial pattern detector.
// The progress width must hold every value 0..PAT_LEN inclusive.
package moore_seq_detector_pkg;

  localparam int PAT_LEN_DEF = 4;
  localparam int CNT_W_DEF   = 8;
  localparam logic [PAT_LEN_DEF-1:0] PAT_INIT_DEF = 4'b1011;

  function automatic int prog_width(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  localparam int PROG_W_DEF = prog_width(PAT_LEN_DEF);

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } det_mode_e;

endpackage

// File: rtl/seq_prefix_match.sv
// Combinational longest-prefix search: the new bit is shifted into the history,
// then the largest k is found whose last k valid bits equal the first k pattern bits.
module seq_prefix_match
  import moore_seq_detector_pkg::*;
#(
  parameter int PAT_LEN = PAT_LEN_DEF,
  parameter int PW      = PROG_W_DEF
) (
  input  logic [PAT_LEN-1:0] hist,
  input  logic [PW-1:0]      vcnt,
  input  logic [PAT_LEN-1:0] pat,
  input  logic               a,
  output logic [PW-1:0]      k
);

  logic [PAT_LEN-1:0] nh;
  logic [PW-1:0]      best;
  logic               ok;

  // nh[0] is the newest bit; pat[PAT_LEN-1] is the first pattern bit, so the
  // oldest of the last kk bits (nh[kk-1]) lines up with pat[PAT_LEN-1].
  always_comb begin
    nh   = {hist[PAT_LEN-2:0], a};
    best = '0;
    ok   = 1'b0;
    for (int kk = 1; kk <= PAT_LEN; kk++) begin
      ok = (kk <= int'(vcnt) + 1);
      for (int j = 0; j < kk; j++) begin
        if (nh[j] != pat[PAT_LEN-kk+j]) ok = 1'b0;
      end
      if (ok) best = PW'(kk);
    end
    k = best;
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with loadable pattern, overlap select and a
// saturating match counter. w is a registered copy of (prog == PAT_LEN).
module moore_seq_detector
  import moore_seq_detector_pkg::*;
#(
  parameter int                 PAT_LEN  = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PAT_INIT = PAT_LEN'(PAT_INIT_DEF),
  parameter int                 CNT_W    = CNT_W_DEF
) (
  input  logic                          clck,
  input  logic                          ares,
  input  logic                          a,
  input  logic                          en,
  input  logic                          ovl,
  input  logic [PAT_LEN-1:0]            pat_in,
  input  logic                          pat_load,
  input  logic                          clr_cnt,
  output logic                          w,
  output logic [CNT_W-1:0]              cnt,
  output logic [prog_width(PAT_LEN)-1:0] dbg_prog,
  output logic [prog_width(PAT_LEN)-1:0] dbg_vcnt,
  output logic [PAT_LEN-1:0]            dbg_hist,
  output logic [PAT_LEN-1:0]            dbg_pat
);

  localparam int              PW      = prog_width(PAT_LEN);
  localparam logic [PW-1:0]   FULL    = PW'(PAT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PW-1:0]      prog;
  logic [PW-1:0]      vcnt;
  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] pat;

  det_mode_e          mode;
  logic               restart;
  logic [PAT_LEN-1:0] hist_eff;
  logic [PW-1:0]      vcnt_eff;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [PW-1:0]      vcnt_nxt;
  logic [PW-1:0]      k;
  logic               hit;

  assign mode = det_mode_e'(ovl);

  // Non-overlapping mode starts a fresh stream after a completed match.
  assign restart  = (mode == MODE_NONOVL) && (prog == FULL);
  assign hist_eff = restart ? '0 : hist;
  assign vcnt_eff = restart ? '0 : vcnt;
  assign hist_nxt = {hist_eff[PAT_LEN-2:0], a};
  assign vcnt_nxt = (vcnt_eff == FULL) ? FULL : vcnt_eff + PW'(1);

  seq_prefix_match #(
    .PAT_LEN (PAT_LEN),
    .PW      (PW)
  ) u_match (
    .hist (hist_eff),
    .vcnt (vcnt_eff),
    .pat  (pat),
    .a    (a),
    .k    (k)
  );

  assign hit = en && !pat_load && (k == FULL);

  always_ff @(posedge clck or posedge ares) begin
    if (ares) begin
      prog <= '0;
      vcnt <= '0;
      hist <= '0;
      pat  <= PAT_INIT;
      cnt  <= '0;
      w    <= 1'b0;
    end else begin
      if (pat_load) begin
        pat  <= pat_in;
        prog <= '0;
        vcnt <= '0;
        hist <= '0;
        w    <= 1'b0;
      end else if (en) begin
        prog <= k;
        vcnt <= vcnt_nxt;
        hist <= hist_nxt;
        w    <= (k == FULL);
      end
      if (clr_cnt) begin
        cnt <= '0;
      end else if (hit && (cnt != CNT_MAX)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign dbg_prog = prog;
  assign dbg_vcnt = vcnt;
  assign dbg_hist = hist;
  assign dbg_pat  = pat;

endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench for moore_seq_detector: a queue-based reference model checked
// every cycle, plus literal expectations for each scenario.
module tb_moore_seq_detector;

  logic       clck     = 1'b0;
  logic       ares     = 1'b0;
  logic       a        = 1'b0;
  logic       en       = 1'b0;
  logic       ovl      = 1'b1;
  logic [3:0] pat_in   = 4'b0000;
  logic       pat_load = 1'b0;
  logic       clr_cnt  = 1'b0;

  logic       w1, w2;
  logic [7:0] cnt1;
  logic [1:0] cnt2;
  logic [2:0] prog1, prog2, vcnt1, vcnt2;
  logic [3:0] hist1, hist2, pat1, pat2;

  int checks = 0;
  int errors = 0;

  moore_seq_detector u_dut (
    .clck(clck), .ares(ares), .a(a), .en(en), .ovl(ovl),
    .pat_in(pat_in), .pat_load(pat_load), .clr_cnt(clr_cnt),
    .w(w1), .cnt(cnt1),
    .dbg_prog(prog1), .dbg_vcnt(vcnt1), .dbg_hist(hist1), .dbg_pat(pat1)
  );

  moore_seq_detector #(.CNT_W(2)) u_dut2 (
    .clck(clck), .ares(ares), .a(a), .en(en), .ovl(ovl),
    .pat_in(pat_in), .pat_load(pat_load), .clr_cnt(clr_cnt),
    .w(w2), .cnt(cnt2),
    .dbg_prog(prog2), .dbg_vcnt(vcnt2), .dbg_hist(hist2), .dbg_pat(pat2)
  );

  always #5 clck = ~clck;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the consumed bits since the last restart, newest at the back.
  bit         mq[$];
  int         mprog = 0;
  int         mcnt8 = 0;
  int         mcnt2 = 0;
  logic [3:0] mpat  = 4'b1011;
  bit         mhit;

  function automatic int longest_prefix(input bit hq[$], input logic [3:0] p);
    bit ok;
    for (int k = hq.size(); k > 0; k--) begin
      ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (hq[hq.size()-k+j] != p[3-j]) ok = 1'b0;
      if (ok) return k;
    end
    return 0;
  endfunction

  always @(posedge clck or posedge ares) begin
    if (ares) begin
      mq.delete();
      mprog = 0;
      mcnt8 = 0;
      mcnt2 = 0;
      mpat  = 4'b1011;
    end else begin
      mhit = 1'b0;
      if (pat_load) begin
        mpat = pat_in;
        mq.delete();
        mprog = 0;
      end else if (en) begin
        if (!ovl && mprog == 4) mq.delete();
        mq.push_back(a);
        if (mq.size() > 4) void'(mq.pop_front());
        mprog = longest_prefix(mq, mpat);
        mhit  = (mprog == 4);
      end
      if (clr_cnt) begin
        mcnt8 = 0;
        mcnt2 = 0;
      end else if (mhit) begin
        if (mcnt8 < 255) mcnt8++;
        if (mcnt2 < 3) mcnt2++;
      end
    end
  end

  always @(negedge clck) begin
    if (!ares) begin
      chk("cmp_w", w1, mprog == 4);
      chk("cmp_cnt", cnt1, mcnt8);
      chk("cmp_prog", prog1, mprog);
      chk("cmp_vcnt", vcnt1, mq.size());
      chk("cmp_pat", pat1, mpat);
      chk("cmp_w2", w2, mprog == 4);
      chk("cmp_cnt2", cnt2, mcnt2);
      chk("cmp_prog2", prog2, mprog);
    end
  end

  task automatic step(input logic av, input logic ev, input logic pl, input logic cc);
    @(negedge clck);
    a        = av;
    en       = ev;
    pat_load = pl;
    clr_cnt  = cc;
    @(posedge clck);
    #1;
  endtask

  task automatic feed(input string tag, input logic [15:0] bits, input int n,
                      input logic [15:0] wexp);
    for (int i = 0; i < n; i++) begin
      step(bits[n-1-i], 1'b1, 1'b0, 1'b0);
      chk({tag, "_w"}, w1, wexp[n-1-i]);
    end
  endtask

  // Reset pulse placed strictly between clock edges.
  task automatic do_reset();
    @(negedge clck);
    #1;
    en = 1'b0; pat_load = 1'b0; clr_cnt = 1'b0;
    ares = 1'b1;
    #2;
    chk("rst_w", w1, 0);
    chk("rst_cnt", cnt1, 0);
    chk("rst_prog", prog1, 0);
    chk("rst_cnt2", cnt2, 0);
    ares = 1'b0;
  endtask

  initial begin
    #2 ares = 1'b1;
    #4;
    chk("init_w", w1, 0);
    chk("init_cnt", cnt1, 0);
    chk("init_pat", pat1, 4'b1011);
    ares = 1'b0;

    ovl = 1'b1;
    feed("ovl_1011", 16'b1011011, 7, 16'b0001001);
    chk("ovl_cnt", cnt1, 2);

    do_reset();
    ovl = 1'b0;
    feed("nonovl_1011", 16'b1011011, 7, 16'b0001000);
    chk("nonovl_cnt", cnt1, 1);

    do_reset();
    ovl = 1'b1;
    pat_in = 4'b1111;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("load_pat", pat1, 4'b1111);
    chk("load_prog", prog1, 0);
    feed("ovl_1111", 16'b111111, 6, 16'b000111);
    chk("ovl_1111_cnt", cnt1, 3);

    do_reset();
    pat_in = 4'b1111;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    ovl = 1'b0;
    feed("nonovl_1111", 16'b111111, 6, 16'b000100);
    chk("nonovl_1111_cnt", cnt1, 1);

    feed("pre_rst", 16'b101, 3, 16'b000);
    chk("pre_rst_prog", prog1, 1);
    chk("pre_rst_cnt", cnt1, 1);
    do_reset();
    chk("post_rst_pat", pat1, 4'b1011);
    ovl = 1'b1;
    feed("post_rst", 16'b1, 1, 16'b0);
    chk("post_rst_prog", prog1, 1);
    feed("post_rst_tail", 16'b011, 3, 16'b001);
    chk("post_rst_cnt", cnt1, 1);

    do_reset();
    feed("gap_head", 16'b10, 2, 16'b00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("gap_w", w1, 0);
      chk("gap_prog", prog1, 2);
    end
    feed("gap_tail", 16'b11, 2, 16'b01);
    chk("gap_cnt", cnt1, 1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("hold_w", w1, 1);
      chk("hold_cnt", cnt1, 1);
    end

    do_reset();
    feed("sat", 16'b1011011011011011, 16, 16'b0001001001001001);
    chk("sat_cnt8", cnt1, 5);
    chk("sat_cnt2", cnt2, 3);
    feed("clr_head", 16'b01, 2, 16'b00);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("clr_w", w1, 1);
    chk("clr_cnt8", cnt1, 0);
    chk("clr_cnt2", cnt2, 0);
    feed("again", 16'b011, 3, 16'b001);
    chk("again_cnt", cnt1, 1);
    pat_in = 4'b1011;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ld_en_prog", prog1, 0);
    chk("ld_en_w", w1, 0);
    chk("ld_en_vcnt", vcnt1, 0);
    chk("ld_en_cnt", cnt1, 1);
    feed("discard", 16'b011, 3, 16'b000);
    chk("discard_cnt", cnt1, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
